lockstep_fault_mgr: RTL and testbench

Downstream consumer of the dual-core lockstep pair (main/follower mini processors). Compares main and follower read data in each qualified cycle and grades mismatches through an escalation FSM (OK, SUSPECT, ALARM, LOCK). Registers the functional output, which is held in ALARM and forced to zero in LOCK. Provides a keyed clear handshake and a saturating lifetime mismatch counter for the security monitor.

---
 rtl/lockstep_fault_mgr_if.sv | 36 +++
 rtl/lockstep_fault_mgr.sv | 134 +++++++++++++
 tb/tb_lockstep_fault_mgr.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lockstep_fault_mgr_if.sv
// Bundles the compare inputs, clear handshake and status outputs of
// lockstep_fault_mgr. The manager uses the slave modport.
interface lockstep_fault_mgr_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic          cmp_en;
  logic [DW-1:0] main_data;
  logic [DW-1:0] follower_data;
  logic          clr_req;
  logic [7:0]    clr_key;
  logic [DW-1:0] fo_data;
  logic          fo_valid;
  logic          alarm;
  logic          lockdown;
  logic          clr_ack;
  logic [3:0]    strike_cnt;
  logic [CW-1:0] fault_cnt;
  logic [1:0]    fsm_state;

  // Clear handshake: clr_req is a level and clr_key is sampled with it. It is
  // accepted only in ALARM with the right key, and clr_ack then pulses for
  // exactly one cycle. A request that stays high after acceptance does nothing
  // unless the manager is back in ALARM.
  modport master (
    output cmp_en, main_data, follower_data, clr_req, clr_key,
    input  fo_data, fo_valid, alarm, lockdown, clr_ack, strike_cnt, fault_cnt,
           fsm_state
  );

  modport slave (
    input  cmp_en, main_data, follower_data, clr_req, clr_key,
    output fo_data, fo_valid, alarm, lockdown, clr_ack, strike_cnt, fault_cnt,
           fsm_state
  );
endinterface

// File: rtl/lockstep_fault_mgr.sv
// Lockstep fault manager: compares main and follower read data and escalates
// mismatches through OK -> SUSPECT -> ALARM -> LOCK, gating the functional output.
module lockstep_fault_mgr #(
  parameter int         DW      = 8,
  parameter int         THRESH  = 3,
  parameter int         QUIET   = 4,
  parameter int         CW      = 8,
  parameter logic [7:0] CLR_KEY = 8'hA5
) (
  input logic                 clk,
  input logic                 rst,
  lockstep_fault_mgr_if.slave bus
);
  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_ALARM   = 2'd2,
    ST_LOCK    = 2'd3
  } state_t;

  localparam logic [3:0]    THRESH4   = THRESH[3:0];
  localparam logic [3:0]    QUIET4    = QUIET[3:0];
  localparam logic [CW-1:0] FAULT_MAX = {CW{1'b1}};

  state_t        state;
  logic [DW-1:0] fo_data;
  logic          fo_valid;
  logic          alarm;
  logic          lockdown;
  logic          clr_ack;
  logic [3:0]    strike_cnt;
  logic [3:0]    quiet_cnt;
  logic [CW-1:0] fault_cnt;

  logic       mismatch;
  logic       match;
  logic [3:0] strike_next;
  logic [3:0] quiet_next;

  assign mismatch    = bus.cmp_en && (bus.main_data != bus.follower_data);
  assign match       = bus.cmp_en && (bus.main_data == bus.follower_data);
  assign strike_next = strike_cnt + 4'd1;
  assign quiet_next  = quiet_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_OK;
      fo_data    <= '0;
      fo_valid   <= 1'b0;
      alarm      <= 1'b0;
      lockdown   <= 1'b0;
      clr_ack    <= 1'b0;
      strike_cnt <= '0;
      quiet_cnt  <= '0;
      fault_cnt  <= '0;
    end else begin
      clr_ack <= 1'b0;
      // Lifetime count keeps running in LOCK so the monitor sees ongoing divergence.
      if (mismatch && (fault_cnt != FAULT_MAX)) fault_cnt <= fault_cnt + 1'b1;

      // Output gating follows the state held before this edge.
      case (state)
        ST_OK, ST_SUSPECT: begin
          fo_valid <= bus.cmp_en;
          if (bus.cmp_en) fo_data <= bus.main_data;
        end
        ST_ALARM: fo_valid <= 1'b0;
        default: begin
          fo_data  <= '0;
          fo_valid <= 1'b0;
        end
      endcase

      case (state)
        ST_OK: begin
          if (mismatch) begin
            state      <= ST_SUSPECT;
            strike_cnt <= 4'd1;
            quiet_cnt  <= '0;
          end
        end
        ST_SUSPECT: begin
          if (mismatch) begin
            strike_cnt <= strike_next;
            quiet_cnt  <= '0;
            if (strike_next == THRESH4) begin
              state <= ST_ALARM;
              alarm <= 1'b1;
            end
          end else if (match) begin
            if (quiet_next == QUIET4) begin
              state      <= ST_OK;
              strike_cnt <= '0;
              quiet_cnt  <= '0;
            end else begin
              quiet_cnt <= quiet_next;
            end
          end
        end
        ST_ALARM: begin
          // A fresh mismatch beats a clear arriving in the same cycle.
          if (mismatch) begin
            state    <= ST_LOCK;
            alarm    <= 1'b0;
            lockdown <= 1'b1;
          end else if (bus.clr_req) begin
            if (bus.clr_key == CLR_KEY) begin
              state      <= ST_OK;
              alarm      <= 1'b0;
              strike_cnt <= '0;
              quiet_cnt  <= '0;
              clr_ack    <= 1'b1;
            end else begin
              state    <= ST_LOCK;
              alarm    <= 1'b0;
              lockdown <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.fo_data    = fo_data;
  assign bus.fo_valid   = fo_valid;
  assign bus.alarm      = alarm;
  assign bus.lockdown   = lockdown;
  assign bus.clr_ack    = clr_ack;
  assign bus.strike_cnt = strike_cnt;
  assign bus.fault_cnt  = fault_cnt;
  assign bus.fsm_state  = state;
endmodule

// File: tb/tb_lockstep_fault_mgr.sv
// Directed bench for lockstep_fault_mgr: escalation, clear handshake, lockdown,
// async reset, and lifetime counter saturation on a CW=2 instance.
module tb_lockstep_fault_mgr;
  localparam logic [1:0] S_OK = 2'd0, S_SUS = 2'd1, S_ALM = 2'd2, S_LCK = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  lockstep_fault_mgr_if #(.DW(8), .CW(8)) bus ();
  lockstep_fault_mgr_if #(.DW(8), .CW(2)) bus2 ();

  lockstep_fault_mgr #(.DW(8), .THRESH(3), .QUIET(4), .CW(8), .CLR_KEY(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lockstep_fault_mgr #(.DW(8), .THRESH(3), .QUIET(4), .CW(2), .CLR_KEY(8'hA5)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the main instance for one cycle and land 1 time unit after the edge.
  task automatic cyc(input logic en, input logic [7:0] m, input logic [7:0] f,
                     input logic cr, input logic [7:0] key);
    bus.cmp_en        = en;
    bus.main_data     = m;
    bus.follower_data = f;
    bus.clr_req       = cr;
    bus.clr_key       = key;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input logic en, input logic [7:0] m, input logic [7:0] f);
    bus.cmp_en         = 1'b0;
    bus.clr_req        = 1'b0;
    bus2.cmp_en        = en;
    bus2.main_data     = m;
    bus2.follower_data = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fo_data"},  32'(bus.fo_data),    32'h0);
    chk({tag, "_fo_valid"}, 32'(bus.fo_valid),   32'h0);
    chk({tag, "_alarm"},    32'(bus.alarm),      32'h0);
    chk({tag, "_lockdown"}, 32'(bus.lockdown),   32'h0);
    chk({tag, "_clr_ack"},  32'(bus.clr_ack),    32'h0);
    chk({tag, "_strike"},   32'(bus.strike_cnt), 32'h0);
    chk({tag, "_fault"},    32'(bus.fault_cnt),  32'h0);
    chk({tag, "_state"},    32'(bus.fsm_state),  32'(S_OK));
  endtask

  initial begin
    bus.cmp_en = 1'b0; bus.main_data = '0; bus.follower_data = '0;
    bus.clr_req = 1'b0; bus.clr_key = '0;
    bus2.cmp_en = 1'b0; bus2.main_data = '0; bus2.follower_data = '0;
    bus2.clr_req = 1'b0; bus2.clr_key = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Matching stream: fo_data tracks main_data one cycle late
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, 8'(i), 8'(i), 1'b0, 8'h00);
      chk("stream_fo_data", 32'(bus.fo_data), 32'(i));
      chk("stream_fo_valid", 32'(bus.fo_valid), 32'h1);
    end
    chk("stream_state", 32'(bus.fsm_state), 32'(S_OK));
    chk("stream_fault", 32'(bus.fault_cnt), 32'h0);

    cyc(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("idle_fo_valid", 32'(bus.fo_valid), 32'h0);
    chk("idle_fo_hold", 32'(bus.fo_data), 32'hFF);

    // Single mismatch, then recovery through QUIET matches with an idle gap
    cyc(1'b1, 8'h10, 8'h11, 1'b0, 8'h00);
    chk("sus_state", 32'(bus.fsm_state), 32'(S_SUS));
    chk("sus_strike", 32'(bus.strike_cnt), 32'h1);
    chk("sus_fault", 32'(bus.fault_cnt), 32'h1);
    chk("sus_fo_data", 32'(bus.fo_data), 32'h10);
    cyc(1'b1, 8'h20, 8'h20, 1'b0, 8'h00);
    cyc(1'b1, 8'h21, 8'h21, 1'b0, 8'h00);
    cyc(1'b0, 8'h33, 8'h44, 1'b0, 8'h00);
    chk("sus_idle_state", 32'(bus.fsm_state), 32'(S_SUS));
    chk("sus_idle_fault", 32'(bus.fault_cnt), 32'h1);
    cyc(1'b1, 8'h22, 8'h22, 1'b0, 8'h00);
    chk("sus_q3_state", 32'(bus.fsm_state), 32'(S_SUS));
    cyc(1'b1, 8'h23, 8'h23, 1'b0, 8'h00);
    chk("rec_state", 32'(bus.fsm_state), 32'(S_OK));
    chk("rec_strike", 32'(bus.strike_cnt), 32'h0);
    chk("rec_alarm", 32'(bus.alarm), 32'h0);
    chk("rec_fault", 32'(bus.fault_cnt), 32'h1);

    // m, ok, m, ok, m escalates to ALARM
    cyc(1'b1, 8'h30, 8'h31, 1'b0, 8'h00);
    cyc(1'b1, 8'h40, 8'h40, 1'b0, 8'h00);
    cyc(1'b1, 8'h50, 8'h51, 1'b0, 8'h00);
    chk("esc_strike2", 32'(bus.strike_cnt), 32'h2);
    cyc(1'b1, 8'h60, 8'h60, 1'b0, 8'h00);
    chk("esc_alarm_early", 32'(bus.alarm), 32'h0);
    cyc(1'b1, 8'h70, 8'h71, 1'b0, 8'h00);
    chk("esc_alarm", 32'(bus.alarm), 32'h1);
    chk("esc_state", 32'(bus.fsm_state), 32'(S_ALM));
    chk("esc_strike3", 32'(bus.strike_cnt), 32'h3);
    chk("esc_fault", 32'(bus.fault_cnt), 32'h4);
    chk("esc_fo_data", 32'(bus.fo_data), 32'h70);
    cyc(1'b1, 8'h99, 8'h99, 1'b0, 8'h00);
    chk("alm_fo_hold", 32'(bus.fo_data), 32'h70);
    chk("alm_fo_valid", 32'(bus.fo_valid), 32'h0);
    chk("alm_stays", 32'(bus.fsm_state), 32'(S_ALM));

    // Keyed clear, held request produces a single ack
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    chk("clr_ack", 32'(bus.clr_ack), 32'h1);
    chk("clr_state", 32'(bus.fsm_state), 32'(S_OK));
    chk("clr_alarm", 32'(bus.alarm), 32'h0);
    chk("clr_strike", 32'(bus.strike_cnt), 32'h0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    chk("clr_ack_once", 32'(bus.clr_ack), 32'h0);
    chk("clr_hold_state", 32'(bus.fsm_state), 32'(S_OK));

    // Back to ALARM, wrong key locks
    cyc(1'b1, 8'h81, 8'h01, 1'b0, 8'h00);
    cyc(1'b1, 8'h82, 8'h02, 1'b0, 8'h00);
    cyc(1'b1, 8'h83, 8'h03, 1'b0, 8'h00);
    chk("alm2_state", 32'(bus.fsm_state), 32'(S_ALM));
    chk("alm2_fault", 32'(bus.fault_cnt), 32'h7);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h5A);
    chk("badkey_lockdown", 32'(bus.lockdown), 32'h1);
    chk("badkey_alarm", 32'(bus.alarm), 32'h0);
    chk("badkey_ack", 32'(bus.clr_ack), 32'h0);
    chk("badkey_fo_hold", 32'(bus.fo_data), 32'h83);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    chk("lock_no_ack", 32'(bus.clr_ack), 32'h0);
    chk("lock_stays", 32'(bus.fsm_state), 32'(S_LCK));
    chk("lock_fo_zero", 32'(bus.fo_data), 32'h0);
    cyc(1'b1, 8'hC3, 8'h3C, 1'b0, 8'h00);
    chk("lock_fault", 32'(bus.fault_cnt), 32'h8);
    chk("lock_fo_valid", 32'(bus.fo_valid), 32'h0);
    chk("lock_fo_zero2", 32'(bus.fo_data), 32'h0);

    // Async reset mid-cycle clears LOCK before any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Differing data without cmp_en is not a compare
    cyc(1'b0, 8'h12, 8'h34, 1'b0, 8'h00);
    chk("noen_state", 32'(bus.fsm_state), 32'(S_OK));
    chk("noen_fault", 32'(bus.fault_cnt), 32'h0);

    // Mismatch and valid clear together in ALARM: mismatch wins
    cyc(1'b1, 8'h91, 8'h19, 1'b0, 8'h00);
    cyc(1'b1, 8'h92, 8'h29, 1'b0, 8'h00);
    cyc(1'b1, 8'h93, 8'h39, 1'b0, 8'h00);
    chk("prio_alarm", 32'(bus.alarm), 32'h1);
    cyc(1'b1, 8'h11, 8'h22, 1'b1, 8'hA5);
    chk("prio_state", 32'(bus.fsm_state), 32'(S_LCK));
    chk("prio_ack", 32'(bus.clr_ack), 32'h0);
    chk("prio_fault", 32'(bus.fault_cnt), 32'h4);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("prio_ack_late", 32'(bus.clr_ack), 32'h0);
    chk("prio_fo_zero", 32'(bus.fo_data), 32'h0);

    // CW=2 instance: fault_cnt saturates at 3
    cyc2(1'b1, 8'h01, 8'h02);
    chk("sat_f1", 32'(bus2.fault_cnt), 32'h1);
    cyc2(1'b1, 8'h03, 8'h04);
    chk("sat_f2", 32'(bus2.fault_cnt), 32'h2);
    cyc2(1'b1, 8'h05, 8'h06);
    chk("sat_f3", 32'(bus2.fault_cnt), 32'h3);
    cyc2(1'b1, 8'h07, 8'h08);
    chk("sat_f4", 32'(bus2.fault_cnt), 32'h3);
    cyc2(1'b1, 8'h09, 8'h0A);
    chk("sat_f5", 32'(bus2.fault_cnt), 32'h3);
    chk("sat_state", 32'(bus2.fsm_state), 32'(S_LCK));
    cyc2(1'b0, 8'hAA, 8'h55);
    chk("sat_noen_fault", 32'(bus2.fault_cnt), 32'h3);
    chk("sat_noen_state", 32'(bus2.fsm_state), 32'(S_LCK));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
